// File: rtl/timer_cap_pkg.sv
// rtl/timer_cap_pkg.sv - register map, edge encodings and bit positions for timer_capture
package timer_cap_pkg;

   // Byte offsets of the four registers; only addr[3:2] is decoded
   localparam logic [3:0] REG_CTRL   = 4'h0;
   localparam logic [3:0] REG_STATUS = 4'h4;
   localparam logic [3:0] REG_DATA   = 4'h8;
   localparam logic [3:0] REG_COUNT  = 4'hC;

   typedef enum logic [1:0] {
      EDGE_RISE     = 2'b00,
      EDGE_FALL     = 2'b01,
      EDGE_BOTH     = 2'b10,
      EDGE_BOTH_ALT = 2'b11
   } edge_e;

   // CTRL bit positions
   localparam int CTRL_EN      = 0;
   localparam int CTRL_EDGE_LO = 1;
   localparam int CTRL_IRQ_EN  = 3;

   // STATUS bit positions
   localparam int STAT_NOT_EMPTY = 0;
   localparam int STAT_FULL      = 1;
   localparam int STAT_OVF       = 2;
   localparam int STAT_LEVEL_LO  = 4;
   localparam int STAT_LEVEL_W   = 5;

   // CTRL register image, msb first: IRQ_EN, EDGE[1:0], EN
   typedef struct packed {
      logic  irq_en;
      edge_e edge_sel;
      logic  en;
   } ctrl_t;

   // Does the detected transition qualify under the selected edge mode
   function automatic logic edge_match(input edge_e mode, input logic rise, input logic fall);
      case (mode)
         EDGE_RISE: return rise;
         EDGE_FALL: return fall;
         default:   return rise | fall;
      endcase
   endfunction

endpackage

// File: rtl/cap_fifo.sv
// rtl/cap_fifo.sv - synchronous timestamp FIFO with push/pop, full/empty and fill level
module cap_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 32,
   localparam int AW   = $clog2(DEPTH),
   localparam int LW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic [W-1:0]  head,
   output logic          full,
   output logic          empty,
   output logic [LW-1:0] level
);

   localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
   localparam logic [AW-1:0] PTR_ONE  = 1;
   localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
   localparam logic [LW-1:0] LVL_ONE  = 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (level == LVL_FULL);
   assign empty   = (level == '0);
   assign pop_ok  = pop & ~empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
   assign push_ok = push & (~full | pop_ok);
   assign head    = mem[rd_ptr];

   function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_ONE;
   endfunction

   // Storage array; contents need no reset since level gates visibility
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Read/write pointers and fill level
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok) wr_ptr <= ptr_next(wr_ptr);
         if (pop_ok)  rd_ptr <= ptr_next(rd_ptr);
         case ({push_ok, pop_ok})
            2'b10:   level <= level + LVL_ONE;
            2'b01:   level <= level - LVL_ONE;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/timer_capture.sv
// rtl/timer_capture.sv - input-capture timer: tick counter, pin edge timestamps into a FIFO, register port, irq
// Optional build macro: TIMER_CAP_FILTER_EN adds a 3-sample stability filter on the synchronized pin
module timer_capture #(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick_in,
   input  logic        cap_in,
   input  logic        sel,
   input  logic        we,
   input  logic [3:0]  addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   import timer_cap_pkg::*;

   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   ctrl_t            ctrl;
   logic [CNT_W-1:0] cnt;
   logic             sync1;
   logic             sync2;
   logic             prev_lvl;
   logic             lvl_now;
   logic             rise;
   logic             fall;
   logic             cap_hit;
   logic             cap_pend;
   logic [CNT_W-1:0] cap_val;
   logic             ovf;
   logic [CNT_W-1:0] fifo_head;
   logic             fifo_full;
   logic             fifo_empty;
   logic [LW-1:0]    fifo_level;
   logic [3:0]       reg_off;
   logic             rd_acc;
   logic             wr_acc;
   logic             wr_ctrl;
   logic             wr_status;
   logic             wr_count;
   logic             pop;
   logic [31:0]      status_word;
   logic             unused_bits;

   assign reg_off   = {addr[3:2], 2'b00};
   assign rd_acc    = sel & ~we;
   assign wr_acc    = sel & we;
   assign wr_ctrl   = wr_acc && (reg_off == REG_CTRL);
   assign wr_status = wr_acc && (reg_off == REG_STATUS);
   assign wr_count  = wr_acc && (reg_off == REG_COUNT);
   assign pop       = rd_acc && (reg_off == REG_DATA) && !fifo_empty;

   // Byte-lane bits of addr and wdata bits beyond the register fields carry no meaning
   assign unused_bits = ^{addr[1:0], wdata};

   // Two-flop synchronizer for the asynchronous capture pin
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= cap_in;
         sync2 <= sync1;
      end
   end

`ifdef TIMER_CAP_FILTER_EN
   logic hist1;
   logic hist2;

   // Two older synchronized samples; the level moves only when all three agree
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hist1 <= 1'b0;
         hist2 <= 1'b0;
      end else begin
         hist1 <= sync2;
         hist2 <= hist1;
      end
   end

   assign lvl_now = (sync2 == hist1 && hist1 == hist2) ? sync2 : prev_lvl;
`else
   assign lvl_now = sync2;
`endif

   // Previous accepted pin level, the reference for edge detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) prev_lvl <= 1'b0;
      else      prev_lvl <= lvl_now;
   end

   assign rise    = lvl_now & ~prev_lvl;
   assign fall    = ~lvl_now & prev_lvl;
   assign cap_hit = ctrl.en & edge_match(ctrl.edge_sel, rise, fall);

   // Latch the pre-increment count of the detect cycle; the FIFO push follows a cycle later
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cap_pend <= 1'b0;
         cap_val  <= '0;
      end else begin
         cap_pend <= cap_hit;
         if (cap_hit) cap_val <= cnt;
      end
   end

   cap_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (CNT_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (cap_pend),
      .push_data (cap_val),
      .pop       (pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   // CTRL register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         ctrl <= '0;
      else if (wr_ctrl) ctrl <= ctrl_t'(wdata[3:0]);
   end

   // Capture counter: a COUNT write wins over a same-cycle tick; wraps silently
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                     cnt <= '0;
      else if (wr_count)            cnt <= wdata[CNT_W-1:0];
      else if (ctrl.en && tick_in)  cnt <= cnt + CNT_ONE;
   end

   // Overflow flag: set on a dropped push, cleared by writing 1 to STATUS bit 2; set wins a tie
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf <= 1'b0;
      end else if (cap_pend && fifo_full && !pop) begin
         ovf <= 1'b1;
      end else if (wr_status && wdata[STAT_OVF]) begin
         ovf <= 1'b0;
      end
   end

   // STATUS read image
   always_comb begin
      status_word = '0;
      status_word[STAT_NOT_EMPTY] = ~fifo_empty;
      status_word[STAT_FULL]      = fifo_full;
      status_word[STAT_OVF]       = ovf;
      status_word[STAT_LEVEL_LO +: STAT_LEVEL_W] = STAT_LEVEL_W'(fifo_level);
   end

   // Registered read data; holds its value between reads
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata <= '0;
      end else if (rd_acc) begin
         case (reg_off)
            REG_CTRL:   rdata <= {28'b0, ctrl};
            REG_STATUS: rdata <= status_word;
            REG_DATA:   rdata <= fifo_empty ? 32'b0 : 32'(fifo_head);
            REG_COUNT:  rdata <= 32'(cnt);
            default:    rdata <= '0;
         endcase
      end
   end

   // Level interrupt, registered one cycle behind the state it reflects
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) irq <= 1'b0;
      else      irq <= ctrl.irq_en & (~fifo_empty | ovf);
   end

endmodule

// File: tb/tb_timer_capture.sv
// tb/tb_timer_capture.sv - randomized and directed bench for timer_capture against a behavioural model
module tb_timer_capture;

   localparam int DEPTH = 4;
   localparam int CW    = 8;
`ifdef TIMER_CAP_FILTER_EN
   localparam int PUSH_LAT = 5;
`else
   localparam int PUSH_LAT = 3;
`endif
   localparam int EXTRA = PUSH_LAT - 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        tick_in = 1'b0;
   logic        cap_in = 1'b0;
   logic        sel = 1'b0;
   logic        we = 1'b0;
   logic [3:0]  addr = '0;
   logic [31:0] wdata = '0;
   wire  [31:0] rdata;
   wire         irq;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   timer_capture #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
      .clk     (clk),
      .rst     (rst),
      .tick_in (tick_in),
      .cap_in  (cap_in),
      .sel     (sel),
      .we      (we),
      .addr    (addr),
      .wdata   (wdata),
      .rdata   (rdata),
      .irq     (irq)
   );

   // ---------------- behavioural model ----------------
   int m_cnt = 0;
   int m_ctrl = 0;
   int q[$];
   bit m_ovf = 0;
   bit m_irq = 0;
   bit m_rd_valid = 0;
   int m_rdata = 0;
   bit m_lvl = 0;
   bit sched = 0;
   int sched_val = 0;
   bit ph[5];

   task automatic model_reset();
      m_cnt = 0; m_ctrl = 0; q.delete(); m_ovf = 0; m_irq = 0;
      m_rd_valid = 0; m_rdata = 0; m_lvl = 0; sched = 0; sched_val = 0;
      for (int i = 0; i < 5; i++) ph[i] = 0;
   endtask

   task automatic model_step();
      int  ctrl0, cnt0, off, mode;
      bit  ne0, ovf0, rd, wr, pop, en, cand, rs, fl, hit;
      ctrl0 = m_ctrl; cnt0 = m_cnt; ne0 = (q.size() > 0); ovf0 = m_ovf;
      rd = sel && !we; wr = sel && we;
      off = int'({addr[3:2], 2'b00});
      for (int i = 4; i > 0; i--) ph[i] = ph[i-1];
      ph[0] = cap_in;
      m_rd_valid = rd;
      pop = 0;
      if (rd) begin
         case (off)
            0:  m_rdata = ctrl0;
            4:  m_rdata = (q.size() << 4) | (int'(ovf0) << 2) | (int'(q.size() == DEPTH) << 1) | int'(ne0);
            8:  begin
                   if (ne0) begin m_rdata = q[0]; pop = 1; end
                   else m_rdata = 0;
                end
            default: m_rdata = cnt0;
         endcase
      end
      if (pop) void'(q.pop_front());
      if (wr && off == 4 && wdata[2]) m_ovf = 0;
      if (sched) begin
         if (q.size() < DEPTH) q.push_back(sched_val);
         else m_ovf = 1;
      end
`ifdef TIMER_CAP_FILTER_EN
      cand = (ph[2] == ph[3] && ph[3] == ph[4]) ? ph[2] : m_lvl;
`else
      cand = ph[2];
`endif
      rs = cand && !m_lvl;
      fl = !cand && m_lvl;
      en = ctrl0[0];
      mode = (ctrl0 >> 1) & 3;
      hit = en && ((mode == 0) ? rs : (mode == 1) ? fl : (rs || fl));
      sched = hit; sched_val = cnt0; m_lvl = cand;
      if (wr && off == 12) m_cnt = int'(wdata) & ((1 << CW) - 1);
      else if (en && tick_in) m_cnt = (cnt0 + 1) % (1 << CW);
      if (wr && off == 0) m_ctrl = int'(wdata & 32'hF);
      m_irq = ctrl0[3] && (ne0 || ovf0);
   endtask

   always @(posedge clk) begin
      if (!rst) model_reset();
      else      model_step();
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (m_rd_valid) chk("model_rdata", rdata, m_rdata);
      chk("model_irq", {31'b0, irq}, {31'b0, m_irq});
   end

   // ---------------- drivers ----------------
   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic rd(input logic [3:0] a, output logic [31:0] d);
      @(negedge clk); sel = 1; we = 0; addr = a;
      @(negedge clk); sel = 0; d = rdata;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] v);
      @(negedge clk); sel = 1; we = 1; addr = a; wdata = v;
      @(negedge clk); sel = 0; we = 0;
   endtask

   initial begin
      logic [31:0] d;
      logic [31:0] prv;

      // Reset with the pin held high; no capture once EN is set later
      cap_in = 1; rst = 0;
      cycles(3); rst = 1;
      rd(4'h0, d); chk("reset_ctrl", d, 0);
      rd(4'h4, d); chk("reset_status", d, 0);
      rd(4'h8, d); chk("reset_data", d, 0);
      rd(4'hC, d); chk("reset_count", d, 0);
      chk("reset_irq", {31'b0, irq}, 0);
      cycles(8); wr(4'h0, 32'h1); cycles(10);
      rd(4'h4, d); chk("no_capture_at_release", d, 0);
      wr(4'h0, 32'h0); cap_in = 0; cycles(10);

      // Rising-edge timestamp with the counter preloaded to 100
      tick_in = 1;
      wr(4'hC, 32'd100); wr(4'h0, 32'h9); cycles(3);
      cap_in = 1; cycles(PUSH_LAT + 3);
      rd(4'h4, d); chk("rise_status", d, 32'h11);
      chk("rise_irq", {31'b0, irq}, 1);
      rd(4'h8, d); chk("rise_ts", d, 105 + EXTRA);
      rd(4'h4, d); chk("rise_status_after", d, 32'h00);
      cycles(2); chk("rise_irq_after", {31'b0, irq}, 0);

      // Both edges, five captures into a 4-deep FIFO
      wr(4'h0, 32'hD);
      for (int i = 0; i < 5; i++) begin cap_in = ~cap_in; cycles(8); end
      rd(4'h4, d); chk("ovf_status", d, 32'h47);
      chk("ovf_irq", {31'b0, irq}, 1);
      rd(4'h8, prv);
      for (int i = 0; i < 3; i++) begin
         rd(4'h8, d); chk("ovf_spacing", (d - prv) & 32'hFF, 8); prv = d;
      end
      rd(4'h4, d); chk("ovf_status_drained", d, 32'h04);
      chk("ovf_irq_held", {31'b0, irq}, 1);
      wr(4'h4, 32'h4); cycles(2);
      rd(4'h4, d); chk("w1c_status", d, 32'h00);
      chk("w1c_irq", {31'b0, irq}, 0);

      // Full FIFO, DATA pop in the same cycle as a push
      for (int i = 0; i < 4; i++) begin cap_in = ~cap_in; cycles(8); end
      @(negedge clk); cap_in = ~cap_in;
      repeat (PUSH_LAT - 1) @(negedge clk);
      rd(4'h8, d);
      cycles(4);
      rd(4'h4, d); chk("pushpop_status", d, 32'h43);
      for (int i = 0; i < 4; i++) rd(4'h8, d);
      rd(4'h4, d); chk("pushpop_drained", d, 32'h00);

      // Counter wrap at 8 bits, and COUNT write beating a tick
      tick_in = 0;
      wr(4'hC, 32'hFF);
      @(negedge clk); tick_in = 1;
      @(negedge clk); tick_in = 0; cap_in = ~cap_in;
      cycles(PUSH_LAT + 3);
      rd(4'h8, d); chk("wrap_ts", d, 0);
      @(negedge clk); sel = 1; we = 1; addr = 4'hC; wdata = 32'h5A; tick_in = 1;
      @(negedge clk); sel = 0; we = 0; tick_in = 0;
      rd(4'hC, d); chk("count_write_vs_tick", d, 32'h5A);
      wr(4'hC, 32'h1234);
      rd(4'hC, d); chk("count_truncate", d, 32'h34);

      // Short pulses
      wr(4'h0, 32'h0); cap_in = 0; cycles(10);
      wr(4'hC, 32'h33); wr(4'h0, 32'hD); cycles(2);
`ifdef TIMER_CAP_FILTER_EN
      cap_in = 1; cycles(2); cap_in = 0; cycles(12);
      rd(4'h4, d); chk("glitch_rejected", d, 32'h00);
      cap_in = 1; cycles(4); cap_in = 0; cycles(12);
`else
      cap_in = 1; cycles(2); cap_in = 0; cycles(12);
`endif
      rd(4'h4, d); chk("pulse_status", d, 32'h21);
      rd(4'h8, d); chk("pulse_ts0", d, 32'h33);
      rd(4'h8, d); chk("pulse_ts1", d, 32'h33);

      // Randomized traffic checked cycle by cycle against the model
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         tick_in = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 5) == 0) cap_in = ~cap_in;
         sel   = ($urandom_range(0, 2) == 0);
         we    = 1'($urandom_range(0, 1));
         addr  = 4'($urandom_range(0, 15));
         wdata = $urandom;
         if (addr[3:2] == 2'b00 && $urandom_range(0, 3) != 0) wdata[0] = 1'b1;
      end
      @(negedge clk); sel = 0; we = 0; tick_in = 0;

      // Reset in the middle of operation
      wr(4'h0, 32'hD); cap_in = ~cap_in; cycles(PUSH_LAT + 3);
      @(negedge clk); #1 rst = 0;
      @(negedge clk); rst = 1;
      rd(4'h4, d); chk("midreset_status", d, 0);
      rd(4'h0, d); chk("midreset_ctrl", d, 0);
      rd(4'hC, d); chk("midreset_count", d, 0);
      chk("midreset_irq", {31'b0, irq}, 0);

      cycles(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/timer_capture.md
# timer_capture

Input-capture companion to the timer peripheral: timestamps external edges on a pin, the inbound counterpart to the timer's outbound tick. A capture counter advances on the timer's prescaled tick. On each qualifying edge of `cap_in`, the block pushes the counter value into a small FIFO and raises an interrupt. The CPU reads the FIFO and configures the block through a simple memory-mapped register port.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: timestamp FIFO entries; power of two, 2..16.
- `CNT_W`, default 32: capture counter width, 8..32; narrower values are zero-extended on `rdata`.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-low.
- `tick_in`  in  1: one-cycle prescaled tick from the timer; advances the counter.
- `cap_in`  in  1: asynchronous external capture pin.
- `sel`  in  1: register access strobe, one cycle per access.
- `we`  in  1: 1 = write, 0 = read; qualified by `sel`.
- `addr`  in  4: byte offset; bits [1:0] are ignored.
- `wdata`  in  32: write data.
- `rdata`  out  32: read data, registered.
- `irq`  out  1: level interrupt.

## Operation
- Registers:
  - CTRL at 0x0, R/W: bit0 EN; bits[2:1] EDGE (00 rising, 01 falling, 10/11 both); bit3 IRQ_EN.
  - STATUS at 0x4, R: bit0 NOT_EMPTY, bit1 FULL, bit2 OVF, bits[8:4] LEVEL.
    - W1C on bit2 only.
  - DATA at 0x8, R: returns the oldest timestamp and pops it.
    - Writes are ignored.
  - COUNT at 0xC, R/W: live counter value.
    - A write loads `wdata[CNT_W-1:0]`.
- Counter:
  - Increments by 1 on `tick_in` while EN=1 and holds while EN=0.
  - Wraps from 2^CNT_W-1 to 0 with no flag.
  - A COUNT write takes priority over a same-cycle tick.
- Input path: 2-flop synchronizer, then a 1-flop previous-value register for edge detection.
- Capture:
  - Occurs when EN=1 and the synchronized input shows an edge matching EDGE.
  - The captured value is the counter value in the edge-detect cycle, before that cycle's increment.
- FIFO push, non-full: store the timestamp and increment LEVEL.
- FIFO push, full, no pop: drop the new timestamp, set OVF, leave contents unchanged.
- Push and pop in the same cycle:
  - Both succeed and LEVEL is unchanged, including when full.
  - OVF is not set.
- DATA read when empty: `rdata`=0, no state change.
- `irq` = IRQ_EN & (NOT_EMPTY | OVF).
- Clearing EN:
  - Stops capture and counting.
  - Does not flush the FIFO or clear OVF.
- Unmapped offsets (bits[3:2] only, so none exist): no side effect.

## Timing
- Reset values:
  - `rdata`=0, `irq`=0, CTRL=0, counter=0, FIFO empty, OVF=0.
  - Synchronizer and edge flops are 0, so a high `cap_in` at reset release sees a rising edge.
- Pin-to-FIFO latency: `cap_in` change to LEVEL increment is 3 to 4 clk, depending on asynchronous phase. Without the filter: 2 sync, 1 detect, push registered.
- Minimum resolvable pulse: 2 clk high plus 2 clk low without the filter.
- Read timing: `rdata` is valid the cycle after `sel & ~we`.
- Pop timing: the DATA pop takes effect in the `sel` cycle, so back-to-back DATA reads return successive entries.
- Write timing: register writes take effect at the clock edge of the `sel` cycle.
- IRQ timing: `irq` updates one cycle after the causing state change (registered).
- Reset asserted mid-operation clears everything immediately. Captured data is lost.

## Configuration
- `TIMER_CAP_FILTER_EN`, when defined:
  - Adds a 3-sample stability filter after the synchronizer. The filtered level changes only when 3 consecutive synchronized samples agree.
  - Latency grows by 2 clk.
  - Pulses shorter than 3 clk are rejected.
- Without the macro: unfiltered synchronized input, with the latencies given above.

## Structure
- Package `timer_cap_pkg` contains:
  - Register offsets CTRL/STATUS/DATA/COUNT.
  - EDGE encodings.
  - CTRL and STATUS bit positions.
- Sub-module `cap_fifo`:
  - Parameterized synchronous FIFO with push/pop, full/empty and level.
  - Pointer wrap is based on FIFO_DEPTH.
- Top level holds the register file, counter, synchronizer, optional filter, edge detect and IRQ logic.

## Test plan
- Reset, then read all four registers: all return 0 and `irq`=0.
  - With `cap_in` held high through reset release and EN set afterwards: no capture.
- Rising-edge timestamp:
  - CTRL=0x9, ticks every cycle, COUNT preloaded to 100, rising edge on `cap_in`.
  - DATA returns the counter at edge detect (value checked by model).
  - STATUS LEVEL goes 1 to 0; `irq` rises then falls after the DATA read.
- Both-edges, overflow and W1C clear:
  - EDGE=both, 5 edges with FIFO_DEPTH=4: LEVEL=4, FULL=1, OVF=1.
  - The 4 entries read back in order.
  - Writing STATUS bit2 clears OVF; `irq` drops once empty.
- Simultaneous push and pop:
  - FIFO full, DATA read in the same cycle as a capture: LEVEL stays 4, OVF stays 0.
- Counter wrap with CNT_W=8:
  - COUNT=0xFF, one tick, then capture: timestamp 0x00.
  - COUNT write coinciding with a tick loads `wdata` exactly.
- Filter with `TIMER_CAP_FILTER_EN`:
  - 2-clk glitch: no capture.
  - 4-clk pulse: two captures under EDGE=both.
